conv_frame_sequencer: RTL

- Controller that sequences the 3x3 convolution datapath over one IMG_W x IMG_H frame of 16-bit pixels.
- Accepts a pixel stream with a valid/ready handshake and can optionally load 9 kernel coefficients first.
- Drives line-buffer write strobes and addresses, and tells the MAC datapath when a full 3x3 window is present.
- Sits between the pixel source and the convolution datapath (line buffers, kernel regs, MAC producing 32-bit results).

---
 rtl/conv_frame_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/conv_frame_sequencer.sv
// Sequences a 3x3 convolution over one IMG_W x IMG_H frame: an optional kernel load, then a pixel raster with window strobes.
// 1-cycle latency from input handshake to strobes; input is held off while an unconsumed window is pending.
module conv_frame_sequencer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        load_k,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        k_we,
  output logic [3:0]  k_addr,
  output logic        pix_we,
  output logic [4:0]  pix_col,
  output logic [4:0]  pix_row,
  output logic [15:0] pix_data,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [4:0]  win_row,
  output logic [4:0]  win_col,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, LOAD_K, STREAM, FLUSH} state_t;

  localparam logic [4:0] LAST_COL = 5'(IMG_W - 1);
  localparam logic [4:0] LAST_ROW = 5'(IMG_H - 1);
  localparam logic [3:0] LAST_K   = 4'(K * K - 1);

  state_t     state;
  logic [4:0] col;
  logic [4:0] row;
  logic [3:0] kidx;
  logic       hs;

  // A pending window blocks new pixels unless it is consumed this very cycle.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      LOAD_K:  in_ready = 1'b1;
      STREAM:  in_ready = !win_valid || win_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign hs = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      col        <= 5'd0;
      row        <= 5'd0;
      kidx       <= 4'd0;
      k_we       <= 1'b0;
      k_addr     <= 4'd0;
      pix_we     <= 1'b0;
      pix_col    <= 5'd0;
      pix_row    <= 5'd0;
      pix_data   <= 16'd0;
      win_valid  <= 1'b0;
      win_row    <= 5'd0;
      win_col    <= 5'd0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      k_we       <= 1'b0;
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      if (win_valid && win_ready) win_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            col   <= 5'd0;
            row   <= 5'd0;
            kidx  <= 4'd0;
            state <= load_k ? LOAD_K : STREAM;
          end
        end

        LOAD_K: begin
          if (hs) begin
            k_we     <= 1'b1;
            k_addr   <= kidx;
            pix_data <= in_data;
            kidx     <= kidx + 4'd1;
            if (kidx == LAST_K) state <= STREAM;
          end
        end

        STREAM: begin
          if (hs) begin
            pix_we   <= 1'b1;
            pix_col  <= col;
            pix_row  <= row;
            pix_data <= in_data;
            // Rows 0-1 and columns 0-1 only fill the line buffers.
            if (row >= 5'd2 && col >= 5'd2) begin
              win_valid <= 1'b1;
              win_row   <= row;
              win_col   <= col;
            end
            if (col == LAST_COL) begin
              col <= 5'd0;
              if (row == LAST_ROW) state <= FLUSH;
              else                 row   <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
          end
        end

        FLUSH: begin
          // The last pixel always opens a window, so wait for its consumption.
          if (win_valid && win_ready) begin
            frame_done <= 1'b1;
            busy       <= 1'b0;
            col        <= 5'd0;
            row        <= 5'd0;
            kidx       <= 4'd0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
